// File: rtl/prison_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prison_pkg
// Description : Shared constants, item type and FSM state encoding for the
//               100-prisoners puzzle block.
// Revision    : 1.0 - initial release
// ============================================================================
package prison_pkg;

    localparam int          N_ITEMS      = 100;
    localparam int          MAX_TRIES    = 50;
    localparam int          DW           = 8;
    localparam logic [31:0] BOX_KEY      = 32'hDEADBEEF;
    localparam logic [31:0] PRISONER_KEY = 32'hCAFEFACE;

    typedef logic [DW-1:0] item_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_PROBE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/prison_regfile.sv
`default_nettype none
// ============================================================================
// Module      : prison_regfile
// Description : DEPTH x 8 register file with asynchronous clear, a key- and
//               range-guarded write port and a combinational read port.
// Revision    : 1.0 - initial release
// ============================================================================
module prison_regfile
    import prison_pkg::*;
#(
    parameter logic [31:0] KEY   = BOX_KEY,
    parameter int          DEPTH = N_ITEMS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_allow,
    input  logic                     wr_stb,
    input  logic [31:0]              wr_key,
    input  item_t                    wr_sel,
    input  item_t                    wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output item_t                    rd_data,
    output logic                     wr_accept
);

    localparam int AW = $clog2(DEPTH);

    item_t mem_q [DEPTH];
    item_t mem_d [DEPTH];

    // A write lands only when the owner permits it, the key matches and the index is in range
    always_comb begin
        wr_accept = wr_allow && wr_stb && (wr_key == KEY) && (wr_sel < item_t'(DEPTH));
    end

    // Next array contents: unchanged except for the single accepted entry
    always_comb begin
        mem_d = mem_q;
        if (wr_accept) begin
            mem_d[wr_sel[AW-1:0]] = wr_data;
        end
    end

    // Out-of-range read indices return 0, which downstream treats as an invalid item
    always_comb begin
        rd_data = (rd_idx < AW'(DEPTH)) ? mem_q[rd_idx] : '0;
    end

    // Storage with asynchronous clear of every entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/top.sv
`default_nettype none
// ============================================================================
// Module      : top
// Description : 100-prisoners puzzle. Box and prisoner files are loaded via
//               guarded writes; on run, each prisoner follows the loop
//               strategy one box per clock. win is set only if all succeed.
// Revision    : 1.0 - initial release
// ============================================================================
module top #(
    parameter int          N_ITEMS      = 100,
    parameter int          MAX_TRIES    = 50,
    parameter int          DW           = 8,
    parameter logic [31:0] BOX_KEY      = 32'hDEADBEEF,
    parameter logic [31:0] PRISONER_KEY = 32'hCAFEFACE
) (
    input  logic          clk,
    input  logic          rst,
    output logic          win,
    input  logic          load_prisoners,
    input  logic          load_boxes,
    input  logic          run,
    input  logic [DW-1:0] select,
    input  logic [DW-1:0] data,
    input  logic [31:0]   guard_key
);

    import prison_pkg::*;

    state_t        state_q, state_d;
    logic          win_q, win_d;
    logic [6:0]    p_q, p_d;
    logic [6:0]    idx_q, idx_d;
    logic [5:0]    tries_q, tries_d;
    logic [DW-1:0] n_q, n_d;

    logic          wr_allow;
    logic          box_acc;
    logic          pris_acc;
    item_t         box_rd;
    item_t         pris_rd;

    // Files are writable only while no game is in progress
    always_comb begin
        wr_allow = (state_q == ST_IDLE) || (state_q == ST_DONE);
    end

    prison_regfile #(
        .KEY   (BOX_KEY),
        .DEPTH (N_ITEMS)
    ) u_box (
        .clk       (clk),
        .rst       (rst),
        .wr_allow  (wr_allow),
        .wr_stb    (load_boxes),
        .wr_key    (guard_key),
        .wr_sel    (select),
        .wr_data   (data),
        .rd_idx    (idx_q),
        .rd_data   (box_rd),
        .wr_accept (box_acc)
    );

    prison_regfile #(
        .KEY   (PRISONER_KEY),
        .DEPTH (N_ITEMS)
    ) u_pris (
        .clk       (clk),
        .rst       (rst),
        .wr_allow  (wr_allow),
        .wr_stb    (load_prisoners),
        .wr_key    (guard_key),
        .wr_sel    (select),
        .wr_data   (data),
        .rd_idx    (p_q),
        .rd_data   (pris_rd),
        .wr_accept (pris_acc)
    );

    // Game sequencer: fetch a prisoner's number, then chase the box chain until found or out of tries
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        p_d     = p_q;
        idx_d   = idx_q;
        tries_d = tries_q;
        n_d     = n_q;

        if (box_acc || pris_acc) begin
            win_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                    win_d   = 1'b0;
                    p_d     = '0;
                end
            end
            ST_FETCH: begin
                if ((pris_rd == '0) || (pris_rd > DW'(N_ITEMS))) begin
                    state_d = ST_DONE;
                    win_d   = 1'b0;
                end else begin
                    n_d     = pris_rd;
                    idx_d   = 7'(pris_rd - 8'd1);
                    tries_d = '0;
                    state_d = ST_PROBE;
                end
            end
            ST_PROBE: begin
                if (box_rd == n_q) begin
                    if (p_q == 7'(N_ITEMS - 1)) begin
                        state_d = ST_DONE;
                        win_d   = 1'b1;
                    end else begin
                        p_d     = p_q + 7'd1;
                        state_d = ST_FETCH;
                    end
                end else if (tries_q == 6'(MAX_TRIES - 1)) begin
                    state_d = ST_DONE;
                    win_d   = 1'b0;
                end else if ((box_rd == '0) || (box_rd > DW'(N_ITEMS))) begin
                    state_d = ST_DONE;
                    win_d   = 1'b0;
                end else begin
                    idx_d   = 7'(box_rd - 8'd1);
                    tries_d = tries_q + 6'd1;
                end
            end
            ST_DONE: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and result register, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            win_q   <= 1'b0;
            p_q     <= '0;
            idx_q   <= '0;
            tries_q <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            p_q     <= p_d;
            idx_q   <= idx_d;
            tries_q <= tries_d;
            n_q     <= n_d;
        end
    end

    assign win = win_q;

endmodule
`default_nettype wire

// File: tb/tb_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_top
// Description : Self-checking bench for the 100-prisoners block. A plain
//               array model plays the loop strategy and predicts both the
//               outcome and the number of clocks to reach DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_top;
    import prison_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        win;
    logic        load_prisoners;
    logic        load_boxes;
    logic        run;
    logic [7:0]  select;
    logic [7:0]  data;
    logic [31:0] guard_key;

    int n_checks = 0;
    int n_fail   = 0;

    int m_box  [100];
    int m_pris [100];
    int stage_box  [100];
    int stage_pris [100];

    top dut (
        .clk            (clk),
        .rst            (rst),
        .win            (win),
        .load_prisoners (load_prisoners),
        .load_boxes     (load_boxes),
        .run            (run),
        .select         (select),
        .data           (data),
        .guard_key      (guard_key)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 100; i++) begin
            m_box[i]  = 0;
            m_pris[i] = 0;
        end
    endtask

    // Puzzle rules on plain arrays: returns outcome and clocks from run to DONE
    function automatic void model_play(output int w, output int cyc);
        int n, b, v;
        bit found;
        cyc = 1;
        w   = 1;
        for (int p = 0; p < 100; p++) begin
            cyc++;
            n = m_pris[p];
            if (n == 0 || n > 100) begin
                w = 0;
                return;
            end
            b     = n;
            found = 0;
            for (int t = 0; t < 50 && !found; t++) begin
                cyc++;
                v = m_box[b-1];
                if (v == n) begin
                    found = 1;
                end else if (t == 49 || v == 0 || v > 100) begin
                    w = 0;
                    return;
                end else begin
                    b = v;
                end
            end
        end
    endfunction

    // One write cycle; the model applies the same acceptance rules (bench only writes outside games)
    task automatic wr(input logic lb, input logic lp, input logic [31:0] key, input int sel, input int val);
        @(negedge clk);
        load_boxes     = lb;
        load_prisoners = lp;
        guard_key      = key;
        select         = 8'(sel);
        data           = 8'(val);
        if (lb && key == BOX_KEY && sel < 100)      m_box[sel]  = val & 255;
        if (lp && key == PRISONER_KEY && sel < 100) m_pris[sel] = val & 255;
        @(negedge clk);
        load_boxes     = 1'b0;
        load_prisoners = 1'b0;
    endtask

    task automatic load_stage();
        for (int i = 0; i < 100; i++) begin
            wr(1'b1, 1'b0, BOX_KEY, i, stage_box[i]);
            wr(1'b0, 1'b1, PRISONER_KEY, i, stage_pris[i]);
        end
    endtask

    task automatic stage_identity();
        for (int i = 0; i < 100; i++) begin
            stage_box[i]  = i + 1;
            stage_pris[i] = i + 1;
        end
    endtask

    // Play one game; optionally attempt a box[0] write while the FSM is probing
    task automatic run_game(input string tag, input int inject);
        int  w, cyc, k;
        bit  done, injected;
        model_play(w, cyc);
        @(negedge clk);
        run      = 1'b1;
        k        = 0;
        done     = 0;
        injected = 0;
        while (!done && k < 6000) begin
            @(posedge clk);
            k++;
            #1;
            load_boxes = 1'b0;
            if (dut.state_q == ST_DONE) begin
                done = 1;
            end else if (inject > 0 && !injected && k >= inject && dut.state_q == ST_PROBE) begin
                load_boxes = 1'b1;
                guard_key  = BOX_KEY;
                select     = 8'd0;
                data       = 8'd55;
                injected   = 1;
            end
        end
        load_boxes = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_cycles"}, k, cyc);
        check({tag, "_win"}, win, 32'(w));
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_hold_state"}, 32'(dut.state_q), 32'(ST_DONE));
        @(negedge clk);
        run = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_idle_state"}, 32'(dut.state_q), 32'(ST_IDLE));
        check({tag, "_win_after_run"}, win, 32'(w));
    endtask

    initial begin
        int tmp, j;
        rst            = 1'b1;
        load_prisoners = 1'b0;
        load_boxes     = 1'b0;
        run            = 1'b0;
        select         = '0;
        data           = '0;
        guard_key      = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("reset_win", win, 32'd0);
        check("reset_state", 32'(dut.state_q), 32'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;

        // Identity permutation
        stage_identity();
        load_stage();
        run_game("ident", 0);

        // Rejected writes keep win; an accepted one clears it
        wr(1'b1, 1'b0, PRISONER_KEY, 3, 9);
        #1 check("wrongkey_keeps_win", win, 32'd1);
        wr(1'b0, 1'b1, PRISONER_KEY, 120, 7);
        #1 check("range_keeps_win", win, 32'd1);
        wr(1'b1, 1'b1, BOX_KEY, 0, 1);
        #1 check("accept_clears_win", win, 32'd0);
        check("dual_strobe_pris0", 32'(dut.u_pris.mem_q[0]), 32'(m_pris[0]));

        // Asynchronous reset seen before the next clock edge
        run_game("ident2", 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("async_rst_win", win, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_clear();

        // Write attempted during a game is ignored
        stage_identity();
        load_stage();
        run_game("write_in_game", 3);
        check("write_in_game_box0", 32'(dut.u_box.mem_q[0]), 32'd1);

        // Single 100-cycle
        for (int i = 0; i < 100; i++) stage_box[i] = ((i + 1) % 100) + 1;
        load_stage();
        run_game("cycle100", 0);

        // Two 50-cycles
        for (int i = 0; i < 50; i++)  stage_box[i] = ((i + 1) % 50) + 1;
        for (int i = 50; i < 100; i++) stage_box[i] = 50 + ((i - 49) % 50) + 1;
        load_stage();
        run_game("cycle50x2", 0);

        // Reset mid-game, then replay on the cleared files
        stage_identity();
        load_stage();
        @(negedge clk);
        run = 1'b1;
        repeat (50) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_win", win, 32'd0);
        check("midrst_state", 32'(dut.state_q), 32'(ST_IDLE));
        check("midrst_box5", 32'(dut.u_box.mem_q[5]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;
        model_clear();
        run_game("midrst_readback", 0);

        // Swapped keys and out-of-range select change nothing
        for (int i = 0; i < 4; i++) begin
            wr(1'b1, 1'b0, PRISONER_KEY, i, i + 1);
            wr(1'b0, 1'b1, BOX_KEY, i, i + 1);
        end
        wr(1'b1, 1'b1, 32'h12345678, 0, 1);
        wr(1'b1, 1'b0, BOX_KEY, 120, 5);
        wr(1'b0, 1'b1, PRISONER_KEY, 120, 5);
        check("guard_box0", 32'(dut.u_box.mem_q[0]), 32'd0);
        check("guard_pris0", 32'(dut.u_pris.mem_q[0]), 32'd0);
        run_game("guard", 0);

        // Random permutations with random extra writes
        for (int g = 0; g < 6; g++) begin
            for (int i = 0; i < 100; i++) begin
                stage_box[i]  = i + 1;
                stage_pris[i] = i + 1;
            end
            for (int i = 99; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp          = stage_box[i];
                stage_box[i] = stage_box[j];
                stage_box[j] = tmp;
            end
            load_stage();
            for (int r = 0; r < 6; r++) begin
                case ($urandom_range(0, 2))
                    0:       tmp = BOX_KEY;
                    1:       tmp = PRISONER_KEY;
                    default: tmp = $urandom;
                endcase
                wr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'(tmp),
                   $urandom_range(0, 127), $urandom_range(0, 110));
            end
            run_game($sformatf("rand%0d", g), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
